// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RV64 core load/store path.
package riscv_core_pkg;

  localparam int XLEN = 64;
  localparam int BE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    RSP0,
    REQ1,
    RSP1,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD,
    DOUBLE
  } lsu_size_e;

  // Right-justified byte mask covering an access of the given size.
  function automatic logic [BE_W-1:0] size_mask(input lsu_size_e size);
    case (size)
      BYTE:    return 8'h01;
      HALF:    return 8'h03;
      WORD:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_lsu_align.sv
// Combinational lane logic for the LSU: byte enables and store shifts for
// both beats, plus load-beat merge and sign/zero extension.
module riscv_core_lsu_align
  import riscv_core_pkg::*;
(
  input  lsu_size_e        size_i,
  input  logic [2:0]       off_i,
  input  logic             ldext_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  beat0_i,
  input  logic [XLEN-1:0]  beat1_i,
  output logic [BE_W-1:0]  be0_o,
  output logic [BE_W-1:0]  be1_o,
  output logic [XLEN-1:0]  wdata0_o,
  output logic [XLEN-1:0]  wdata1_o,
  output logic [XLEN-1:0]  rdata_o
);

  logic [5:0]        bit_shift;
  logic [2*BE_W-1:0] be_wide;
  logic [2*XLEN-1:0] wdata_wide;
  logic [2*XLEN-1:0] rd_cat;
  logic [XLEN-1:0]   merged;
  logic              sext;

  assign bit_shift = {off_i, 3'b000};

  // Shifting across a double-width window yields beat 0 in the low half and
  // the spill-over for beat 1 in the high half.
  assign be_wide    = {8'h00, size_mask(size_i)} << off_i;
  assign wdata_wide = {{XLEN{1'b0}}, wdata_i} << bit_shift;

  assign be0_o    = be_wide[BE_W-1:0];
  assign be1_o    = be_wide[2*BE_W-1:BE_W];
  assign wdata0_o = wdata_wide[XLEN-1:0];
  assign wdata1_o = wdata_wide[2*XLEN-1:XLEN];

  assign rd_cat = {beat1_i, beat0_i};

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign merged[8*gi +: 8] = rd_cat[8*(32'(off_i) + gi) +: 8];
  end

  assign sext = ~ldext_i;

  always_comb begin
    rdata_o = merged;
    case (size_i)
      BYTE:    rdata_o = {{(XLEN-8){sext & merged[7]}},   merged[7:0]};
      HALF:    rdata_o = {{(XLEN-16){sext & merged[15]}}, merged[15:0]};
      WORD:    rdata_o = {{(XLEN-32){sext & merged[31]}}, merged[31:0]};
      default: rdata_o = merged;
    endcase
  end

endmodule

// File: rtl/riscv_core_lsu.sv
// RV64 load/store unit: req/gnt/rvalid data-memory master with lane alignment.
// RISCV_CORE_LSU_MISALIGN_EN enables two-beat splitting of 8-byte-crossing accesses.
module riscv_core_lsu
  import riscv_core_pkg::*;
(
  input  logic             i_lsu_clk,
  input  logic             i_lsu_rst_n,
  input  logic             i_lsu_valid,
  output logic             o_lsu_ready,
  input  logic             i_lsu_memwrite,
  input  logic [1:0]       i_lsu_size,
  input  logic             i_lsu_ldext,
  input  logic [XLEN-1:0]  i_lsu_addr,
  input  logic [XLEN-1:0]  i_lsu_wdata,
  output logic             o_lsu_busy,
  output logic             o_lsu_done,
  output logic [XLEN-1:0]  o_lsu_rdata,
  output logic             o_lsu_misaligned,
  output logic             o_lsu_mem_req,
  input  logic             i_lsu_mem_gnt,
  output logic [XLEN-1:0]  o_lsu_mem_addr,
  output logic             o_lsu_mem_we,
  output logic [BE_W-1:0]  o_lsu_mem_be,
  output logic [XLEN-1:0]  o_lsu_mem_wdata,
  input  logic             i_lsu_mem_rvalid,
  input  logic [XLEN-1:0]  i_lsu_mem_rdata
);

  lsu_state_e      state_q, state_d;
  logic            we_q;
  lsu_size_e       size_q;
  logic            ldext_q;
  logic [2:0]      off_q;
  logic            cross_q;
  logic            mis_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            mem_we_q;
  logic [BE_W-1:0] mem_be_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [XLEN-1:0] beat0_q;
  logic [XLEN-1:0] beat1_q;

  logic            idle;
  logic            accept;
  lsu_size_e       size_sel;
  logic [2:0]      off_sel;
  logic [XLEN-1:0] wdata_sel;
  logic            cross_in;
  logic            mis_in;
  logic [BE_W-1:0] be0, be1;
  logic [XLEN-1:0] wdata0, wdata1, ld_result;

  assign idle   = (state_q == IDLE);
  assign accept = idle & i_lsu_valid;

  // Beat-0 lanes come from the live request while idle; afterwards the
  // latched request drives beat 1 and the load merge.
  assign size_sel  = idle ? lsu_size_e'(i_lsu_size) : size_q;
  assign off_sel   = idle ? i_lsu_addr[2:0] : off_q;
  assign wdata_sel = idle ? i_lsu_wdata : wdata_q;

`ifdef RISCV_CORE_LSU_MISALIGN_EN
  logic [3:0] n_sel;
  assign n_sel    = 4'd1 << size_sel;
  assign cross_in = ({1'b0, off_sel} + n_sel) > 4'd8;
  assign mis_in   = 1'b0;
`else
  assign cross_in = 1'b0;
  always_comb begin
    mis_in = 1'b0;
    case (size_sel)
      HALF:    mis_in = off_sel[0];
      WORD:    mis_in = |off_sel[1:0];
      DOUBLE:  mis_in = |off_sel;
      default: mis_in = 1'b0;
    endcase
  end
`endif

  riscv_core_lsu_align u_align (
    .size_i   (size_sel),
    .off_i    (off_sel),
    .ldext_i  (ldext_q),
    .wdata_i  (wdata_sel),
    .beat0_i  (beat0_q),
    .beat1_i  (beat1_q),
    .be0_o    (be0),
    .be1_o    (be1),
    .wdata0_o (wdata0),
    .wdata1_o (wdata1),
    .rdata_o  (ld_result)
  );

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
    if (!i_lsu_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_lsu_valid) begin
          state_d = mis_in ? DONE : REQ0;
        end
      end
      REQ0: begin
        if (i_lsu_mem_gnt) begin
          if (!we_q) begin
            state_d = RSP0;
          end else begin
            state_d = cross_q ? REQ1 : DONE;
          end
        end
      end
      RSP0: begin
        if (i_lsu_mem_rvalid) begin
          state_d = cross_q ? REQ1 : DONE;
        end
      end
`ifdef RISCV_CORE_LSU_MISALIGN_EN
      REQ1: begin
        if (i_lsu_mem_gnt) begin
          state_d = we_q ? DONE : RSP1;
        end
      end
      RSP1: begin
        if (i_lsu_mem_rvalid) begin
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
    if (!i_lsu_rst_n) begin
      we_q        <= 1'b0;
      size_q      <= BYTE;
      ldext_q     <= 1'b0;
      off_q       <= 3'd0;
      cross_q     <= 1'b0;
      mis_q       <= 1'b0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      beat0_q     <= '0;
      beat1_q     <= '0;
    end else begin
      if (accept) begin
        we_q    <= i_lsu_memwrite;
        size_q  <= lsu_size_e'(i_lsu_size);
        ldext_q <= i_lsu_ldext;
        off_q   <= i_lsu_addr[2:0];
        cross_q <= cross_in;
        mis_q   <= mis_in;
        wdata_q <= i_lsu_wdata;
        // A faulting access never reaches the bus, so its fields stay put.
        if (!mis_in) begin
          mem_addr_q  <= {i_lsu_addr[XLEN-1:3], 3'b000};
          mem_we_q    <= i_lsu_memwrite;
          mem_be_q    <= be0;
          mem_wdata_q <= wdata0;
        end
      end
      if ((state_q == REQ0) && i_lsu_mem_gnt && cross_q) begin
        mem_addr_q  <= mem_addr_q + 64'd8;
        mem_be_q    <= be1;
        mem_wdata_q <= wdata1;
      end
      if ((state_q == RSP0) && i_lsu_mem_rvalid) begin
        beat0_q <= i_lsu_mem_rdata;
      end
      if ((state_q == RSP1) && i_lsu_mem_rvalid) begin
        beat1_q <= i_lsu_mem_rdata;
      end
    end
  end

  assign o_lsu_ready     = idle;
  assign o_lsu_busy      = ~idle | i_lsu_valid;
  assign o_lsu_done      = (state_q == DONE);
  assign o_lsu_mem_req   = (state_q == REQ0) | (state_q == REQ1);
  assign o_lsu_mem_addr  = mem_addr_q;
  assign o_lsu_mem_we    = mem_we_q;
  assign o_lsu_mem_be    = mem_be_q;
  assign o_lsu_mem_wdata = mem_wdata_q;
  assign o_lsu_rdata     = (o_lsu_done & ~we_q & ~mis_q) ? ld_result : '0;

`ifdef RISCV_CORE_LSU_MISALIGN_EN
  assign o_lsu_misaligned = 1'b0;
`else
  assign o_lsu_misaligned = o_lsu_done & mis_q;
`endif

endmodule

// File: doc/riscv_core_lsu.md
# riscv_core_lsu

Load/store unit for the RV64IMAC core: consumes the memory-control fields produced by the main decoder (memwrite, 2-bit access size, load-extend select) plus the ALU-computed address and store data. It runs a req/gnt/rvalid transaction on a 64-bit data-memory port, generates byte enables, and aligns and sign/zero-extends load data. It also splits accesses that cross an 8-byte boundary into two beats. It sits between the execute and writeback stages and stalls the pipeline while busy.

## Interface
- No parameters; XLEN fixed at 64.
- i_lsu_clk  in  1  core clock; all state on rising edge.
- i_lsu_rst_n  in  1  reset; asynchronous, active-low.
- i_lsu_valid  in  1  access request from the pipeline.
- o_lsu_ready  out  1  LSU can accept a request (state IDLE).
- i_lsu_memwrite  in  1  1 = store, 0 = load.
- i_lsu_size  in  2  00 byte, 01 half, 10 word, 11 double.
- i_lsu_ldext  in  1  0 = sign-extend, 1 = zero-extend (loads only).
- i_lsu_addr  in  64  byte address.
- i_lsu_wdata  in  64  store data, right-justified.
- o_lsu_busy  out  1  pipeline stall: high from acceptance through the done cycle.
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_rdata  out  64  extended load result; valid while o_lsu_done is high.
- o_lsu_misaligned  out  1  one-cycle fault pulse; only when the misalign feature is compiled out.
- o_lsu_mem_req  out  1  bus request.
- i_lsu_mem_gnt  in  1  bus accepts the request this cycle.
- o_lsu_mem_addr  out  64  8-byte-aligned beat address; bits [2:0] are always 0.
- o_lsu_mem_we  out  1  write enable.
- o_lsu_mem_be  out  8  byte enables.
- o_lsu_mem_wdata  out  64  lane-aligned write data.
- i_lsu_mem_rvalid  in  1  read data valid; loads only.
- i_lsu_mem_rdata  in  64  read data.

## Operation
- FSM states:
  - IDLE: on i_lsu_valid, latch all request fields and compute off = addr[2:0] and n = 1<<size. Set cross = (off+n > 8). Go to REQ0.
  - REQ0: hold o_lsu_mem_req. On gnt: if cross, go to RSP0 for a load, REQ1 for a store. If not cross, go to RSP0 for a load, DONE for a store.
  - RSP0: wait for rvalid and capture beat 0 data. Go to REQ1 if cross, else DONE.
  - REQ1: hold o_lsu_mem_req. On gnt: go to RSP1 for a load, DONE for a store.
  - RSP1: wait for rvalid and capture beat 1 data. Go to DONE.
  - DONE: assert o_lsu_done. Go to IDLE.
- Beat 0:
  - addr = {addr[63:3], 3'b0}
  - be = (mask(n) << off)[7:0]
  - wdata = wdata << 8*off
- Beat 1:
  - addr = beat-0 addr + 8, wrapping modulo 2^64
  - be = mask(n) >> (8-off)
  - wdata = wdata >> 8*(8-off)
- Load assembly:
  - Beat-0 bytes [off..7] map to result bytes [0..7-off].
  - Beat-1 bytes map to result bytes [8-off..n-1].
  - Result is then sign- or zero-extended from n bytes per ldext. A doubleword ignores ldext.
- o_lsu_mem_req, addr, we, be and wdata are driven from registered state and held stable until gnt.
- i_lsu_valid outside IDLE is ignored; the pipeline is stalled by o_lsu_busy.
- gnt and rvalid arriving in the same cycle is impossible by protocol; rvalid is never earlier than the cycle after gnt.
- Asynchronous reset at any point forces IDLE and drops o_lsu_mem_req immediately. A half-completed split store is not rolled back.

## Timing
- Reset values:
  - o_lsu_ready = 1
  - o_lsu_busy = 0
  - o_lsu_done = 0
  - o_lsu_misaligned = 0
  - o_lsu_mem_req = 0
  - o_lsu_mem_we = 0
  - o_lsu_mem_be = 0
  - o_lsu_mem_addr, o_lsu_mem_wdata and o_lsu_rdata = 0
- Accept at cycle T; o_lsu_mem_req is asserted at T+1.
- Aligned load with zero wait states: gnt at T+1, rvalid at T+2, done at T+3.
- Aligned store: gnt at T+1, done at T+2.
- Split load: done at T+5 minimum. Split store: done at T+3 minimum.
- Each gnt or rvalid wait cycle adds exactly one cycle.
- o_lsu_ready is 0 from T+1 through the DONE cycle. A new request can be accepted in the cycle after DONE.

## Configuration
- RISCV_CORE_LSU_MISALIGN_EN defined:
  - Crossing accesses are split into two beats as above.
  - o_lsu_misaligned is tied to 0.
- RISCV_CORE_LSU_MISALIGN_EN undefined:
  - Any access with off % n != 0 issues no bus request.
  - IDLE goes directly to DONE; o_lsu_done and o_lsu_misaligned pulse together.
  - o_lsu_rdata = 0.
  - REQ1 and RSP1 are removed.

## Structure
- riscv_core_pkg holds:
  - lsu_state_e: IDLE, REQ0, RSP0, REQ1, RSP1, DONE
  - lsu_size_e: BYTE, HALF, WORD, DOUBLE
  - Constants XLEN = 64 and BE_W = 8
- Sub-module riscv_core_lsu_align is purely combinational. It computes byte-enable mask generation, store lane shifts, and load merge plus extension. The FSM and registers stay in riscv_core_lsu.

## Test plan
- lb addr 0x1003, mem word 0x00000000_80000000 → be 0x08, o_lsu_rdata 0xFFFF_FFFF_FFFF_FF80; done at T+3.
- lhu addr 0x2006, rdata 0x8001_0000_0000_0000 → be 0xC0, o_lsu_rdata 0x0000_0000_0000_8001.
- sd addr 0x3008, wdata 0x1122334455667788, gnt delayed 3 cycles → req held stable, be 0xFF, done 1 cycle after gnt.
- sw addr 0x4006, wdata 0xAABBCCDD, MISALIGN_EN defined → beat 0: addr 0x4000, be 0xC0, wdata[63:48] = 0xCCDD. Beat 1: addr 0x4008, be 0x03, wdata[15:0] = 0xAABB.
- Same sw with MISALIGN_EN undefined → no o_lsu_mem_req, o_lsu_misaligned and o_lsu_done pulse together at T+1.
- ld split at 0x5004, reset asserted in RSP1 → o_lsu_mem_req = 0 and o_lsu_ready = 1 asynchronously; the next request is accepted normally.
